// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the IF-stage PC generator (pc_fetch_ctrl).
// The PC_FETCH_RVC_EN macro (compressed ISA support) is consumed by pc_fetch_ctrl.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_JMP  = 2'd1,
    SRC_BR   = 2'd2,
    SRC_TRAP = 2'd3
  } redir_src_e;

  localparam int INC_WORD = 4;
  localparam int INC_HALF = 2;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: picks one of trap/branch/jump by fixed
// priority trap > branch > jump and reports the winning target and source.
module pc_redirect_arb
  import pc_fetch_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic                trap_valid_i,
  input  logic [PC_WIDTH-1:0] trap_pc_i,
  input  logic                br_valid_i,
  input  logic [PC_WIDTH-1:0] br_pc_i,
  input  logic                jmp_valid_i,
  input  logic [PC_WIDTH-1:0] jmp_pc_i,
  output logic                redir_o,
  output logic [PC_WIDTH-1:0] target_o,
  output redir_src_e          src_o
);

  assign redir_o = trap_valid_i | br_valid_i | jmp_valid_i;

  always_comb begin
    target_o = jmp_pc_i;
    src_o    = SRC_NONE;
    if (trap_valid_i) begin
      target_o = trap_pc_i;
      src_o    = SRC_TRAP;
    end else if (br_valid_i) begin
      target_o = br_pc_i;
      src_o    = SRC_BR;
    end else if (jmp_valid_i) begin
      target_o = jmp_pc_i;
      src_o    = SRC_JMP;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage PC register, fetch-request generator and BOOT/RUN/FAULT FSM.
// Define PC_FETCH_RVC_EN for compressed-ISA support (ilen16_i port, 2-byte alignment).
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int                   PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                trap_valid_i,
  input  logic [PC_WIDTH-1:0] trap_pc_i,
  input  logic                br_valid_i,
  input  logic [PC_WIDTH-1:0] br_pc_i,
  input  logic                jmp_valid_i,
  input  logic [PC_WIDTH-1:0] jmp_pc_i,
  input  logic                fetch_ready_i,
`ifdef PC_FETCH_RVC_EN
  input  logic                ilen16_i,
`endif
  output logic                fetch_valid_o,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                redirect_o,
  output logic [1:0]          redirect_src_o,
  output logic                misalign_o,
  output logic [1:0]          state_o
);

  localparam logic [1:0] ST_BOOT  = BOOT;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_FAULT = FAULT;

  logic [1:0]          state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                redirect_q;
  logic [1:0]          src_q;

  logic                arb_redir;
  logic [PC_WIDTH-1:0] arb_target;
  redir_src_e          arb_src;

  logic                take_redir;
  logic [PC_WIDTH-1:0] take_pc;
  logic [1:0]          take_src;
  logic                take_misalign;
  logic [PC_WIDTH-1:0] pc_inc;

  pc_redirect_arb #(
    .PC_WIDTH(PC_WIDTH)
  ) u_arb (
    .trap_valid_i(trap_valid_i),
    .trap_pc_i   (trap_pc_i),
    .br_valid_i  (br_valid_i),
    .br_pc_i     (br_pc_i),
    .jmp_valid_i (jmp_valid_i),
    .jmp_pc_i    (jmp_pc_i),
    .redir_o     (arb_redir),
    .target_o    (arb_target),
    .src_o       (arb_src)
  );

  // In FAULT only a trap may redirect; BOOT and RUN honour the full arbiter.
  always_comb begin
    take_redir = 1'b0;
    take_pc    = arb_target;
    take_src   = arb_src;
    case (state_q)
      ST_BOOT, ST_RUN: take_redir = arb_redir;
      ST_FAULT: begin
        take_redir = trap_valid_i;
        take_pc    = trap_pc_i;
        take_src   = SRC_TRAP;
      end
      default: take_redir = 1'b0;
    endcase
  end

`ifdef PC_FETCH_RVC_EN
  assign take_misalign = take_pc[0];
  assign pc_inc = pc_q + (ilen16_i ? PC_WIDTH'(INC_HALF) : PC_WIDTH'(INC_WORD));
`else
  assign take_misalign = |take_pc[1:0];
  assign pc_inc = pc_q + PC_WIDTH'(INC_WORD);
`endif

  // Misaligned targets are still loaded so the handler can inspect pc_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      redirect_q <= 1'b0;
      src_q      <= SRC_NONE;
    end else begin
      redirect_q <= 1'b0;
      if (take_redir) begin
        pc_q       <= take_pc;
        redirect_q <= 1'b1;
        src_q      <= take_src;
        state_q    <= take_misalign ? ST_FAULT : ST_RUN;
      end else begin
        case (state_q)
          ST_BOOT: state_q <= ST_RUN;
          ST_RUN: begin
            if (!stall_i && fetch_ready_i) pc_q <= pc_inc;
          end
          ST_FAULT: state_q <= ST_FAULT;
          default:  state_q <= ST_BOOT;
        endcase
      end
    end
  end

  // Request valid/ready: the request at pc_o is offered while fetch_valid_o
  // is high and consumed on the edge where fetch_ready_i is also high;
  // until then it is held with the same address.
  assign fetch_valid_o  = (state_q == ST_RUN) & ~stall_i & ~arb_redir;
  assign pc_o           = pc_q;
  assign redirect_o     = redirect_q;
  assign redirect_src_o = src_q;
  assign misalign_o     = (state_q == ST_FAULT);
  assign state_o        = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed testbench for pc_fetch_ctrl with immediate-assertion checks.
// Builds with or without PC_FETCH_RVC_EN.
module tb_pc_fetch_ctrl;

  localparam int          PC_WIDTH = 32;
  localparam logic [31:0] RV       = 32'h100;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        stall_i = 1'b0;
  logic        trap_valid_i = 1'b0;
  logic [31:0] trap_pc_i = '0;
  logic        br_valid_i = 1'b0;
  logic [31:0] br_pc_i = '0;
  logic        jmp_valid_i = 1'b0;
  logic [31:0] jmp_pc_i = '0;
  logic        fetch_ready_i = 1'b1;
`ifdef PC_FETCH_RVC_EN
  logic        ilen16_i = 1'b0;
`endif
  logic        fetch_valid_o;
  logic [31:0] pc_o;
  logic        redirect_o;
  logic [1:0]  redirect_src_o;
  logic        misalign_o;
  logic [1:0]  state_o;

  int checks   = 0;
  int failures = 0;

  pc_fetch_ctrl #(
    .PC_WIDTH    (PC_WIDTH),
    .RESET_VECTOR(RV)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .trap_valid_i  (trap_valid_i),
    .trap_pc_i     (trap_pc_i),
    .br_valid_i    (br_valid_i),
    .br_pc_i       (br_pc_i),
    .jmp_valid_i   (jmp_valid_i),
    .jmp_pc_i      (jmp_pc_i),
    .fetch_ready_i (fetch_ready_i),
`ifdef PC_FETCH_RVC_EN
    .ilen16_i      (ilen16_i),
`endif
    .fetch_valid_o (fetch_valid_o),
    .pc_o          (pc_o),
    .redirect_o    (redirect_o),
    .redirect_src_o(redirect_src_o),
    .misalign_o    (misalign_o),
    .state_o       (state_o)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_redir();
    trap_valid_i = 1'b0;
    br_valid_i   = 1'b0;
    jmp_valid_i  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic v,
                         input logic r, input logic [1:0] src, input logic m,
                         input logic [1:0] st);
    chk({tag, "_pc"}, pc_o, pc);
    chk({tag, "_valid"}, 32'(fetch_valid_o), 32'(v));
    chk({tag, "_redir"}, 32'(redirect_o), 32'(r));
    chk({tag, "_src"}, 32'(redirect_src_o), 32'(src));
    chk({tag, "_mis"}, 32'(misalign_o), 32'(m));
    chk({tag, "_state"}, 32'(state_o), 32'(st));
  endtask

  initial begin
    // reset values
    #1 rst = 1'b1;
    #1;
    chk_all("reset", RV, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_all("boot", RV, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);

    // sequential fetch from reset vector
    tick();
    chk_all("run0", 32'h100, 1'b1, 1'b0, 2'd0, 1'b0, 2'd1);
    tick();
    chk_all("run1", 32'h104, 1'b1, 1'b0, 2'd0, 1'b0, 2'd1);

    // imem back-pressure holds the request
    fetch_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("hold", 32'h104, 1'b1, 1'b0, 2'd0, 1'b0, 2'd1);
    end
    fetch_ready_i = 1'b1;
    tick();
    chk_all("resume", 32'h108, 1'b1, 1'b0, 2'd0, 1'b0, 2'd1);

    // all three redirects at once under stall: trap wins
    stall_i = 1'b1;
    trap_valid_i = 1'b1; trap_pc_i = 32'h200;
    br_valid_i   = 1'b1; br_pc_i   = 32'h300;
    jmp_valid_i  = 1'b1; jmp_pc_i  = 32'h400;
    #1;
    chk("squash_valid", 32'(fetch_valid_o), 32'd0);
    tick();
    clr_redir();
    #1;
    chk_all("prio", 32'h200, 1'b0, 1'b1, 2'd3, 1'b0, 2'd1);
    tick();
    chk_all("prio_after", 32'h200, 1'b0, 1'b0, 2'd3, 1'b0, 2'd1);
    stall_i = 1'b0;

    // misaligned branch -> FAULT; jump ignored; aligned trap recovers
    br_valid_i = 1'b1; br_pc_i = 32'h302;
    tick();
    clr_redir();
    #1;
`ifdef PC_FETCH_RVC_EN
    chk_all("br302", 32'h302, 1'b1, 1'b1, 2'd2, 1'b0, 2'd1);
`else
    chk_all("br302", 32'h302, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2);
    jmp_valid_i = 1'b1; jmp_pc_i = 32'h400;
    tick();
    clr_redir();
    #1;
    chk_all("fault_jmp", 32'h302, 1'b0, 1'b0, 2'd2, 1'b1, 2'd2);
`endif
    trap_valid_i = 1'b1; trap_pc_i = 32'h80;
    tick();
    clr_redir();
    #1;
    chk_all("recover", 32'h80, 1'b1, 1'b1, 2'd3, 1'b0, 2'd1);

    // wrap at top of address space
    jmp_valid_i = 1'b1; jmp_pc_i = 32'hFFFF_FFFC;
    tick();
    clr_redir();
    #1;
    chk_all("top", 32'hFFFF_FFFC, 1'b1, 1'b1, 2'd1, 1'b0, 2'd1);
    tick();
    chk_all("wrap", 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, 2'd1);

`ifdef PC_FETCH_RVC_EN
    // 16-bit instruction increment and halfword-aligned target
    jmp_valid_i = 1'b1; jmp_pc_i = 32'h10;
    tick();
    clr_redir();
    ilen16_i = 1'b1;
    tick();
    ilen16_i = 1'b0;
    chk_all("rvc_inc", 32'h12, 1'b1, 1'b0, 2'd1, 1'b0, 2'd1);
    br_valid_i = 1'b1; br_pc_i = 32'h22;
    tick();
    clr_redir();
    #1;
    chk_all("rvc_br22", 32'h22, 1'b1, 1'b1, 2'd2, 1'b0, 2'd1);
`endif

    // enter FAULT, misaligned trap stays in FAULT
    br_valid_i = 1'b1; br_pc_i = 32'h301;
    tick();
    clr_redir();
    #1;
    chk_all("fault_in", 32'h301, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2);
    trap_valid_i = 1'b1; trap_pc_i = 32'h81;
    tick();
    clr_redir();
    #1;
    chk_all("fault_trap", 32'h81, 1'b0, 1'b1, 2'd3, 1'b1, 2'd2);
    tick();
    chk_all("fault_idle", 32'h81, 1'b0, 1'b0, 2'd3, 1'b1, 2'd2);

    // asynchronous reset mid-cycle while in FAULT
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", RV, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    #1 rst = 1'b0;
    tick();
    chk_all("rst_run", RV, 1'b1, 1'b0, 2'd0, 1'b0, 2'd1);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
